// File: rtl/button_event_port.sv
// Button input peripheral: four buttons are synchronised, debounced and edge-detected, then queued
// as 3-bit event codes that the CPU drains through a load-mapped FIFO.
module button_event_port #(
    parameter logic [11:0] EVT_ADDR        = 12'd0,
    parameter logic [11:0] STAT_ADDR       = 12'd2,
    parameter int          DEBOUNCE_CYCLES = 290000,
    parameter int          DEPTH           = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        BTNU,
    input  logic        BTNR,
    input  logic        BTND,
    input  logic        BTNL,
    input  logic [11:0] address_dmem,
    input  logic        mem_read,
    input  logic        wren,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        pending
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W + 1)'(DEPTH);

    // Bit order: 0=U, 1=R, 2=D, 3=L; event code is bit index + 1.
    logic [3:0]       btn_raw;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       stable_q, stable_d, stable_prev_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       pend_q, pend_d, rise, grant;
    logic [2:0]       push_code;
    logic             push_req;

    logic [2:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             evt_sel, stat_sel, full, empty, pop, clr, do_push;

    assign btn_raw = {BTNL, BTND, BTNR, BTNU};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) stable_d[i] = sync2_q[i];
                else                      cnt_d[i]    = cnt_q[i] + 1'b1;
            end
        end
    end

    assign rise = stable_q & ~stable_prev_q;

    always_comb begin
        grant     = 4'b0000;
        push_code = 3'd0;
        if (pend_q[0])      begin grant = 4'b0001; push_code = 3'd1; end
        else if (pend_q[1]) begin grant = 4'b0010; push_code = 3'd2; end
        else if (pend_q[2]) begin grant = 4'b0100; push_code = 3'd3; end
        else if (pend_q[3]) begin grant = 4'b1000; push_code = 3'd4; end
    end

    assign push_req = |pend_q;
    // A press arriving while its bit is still set merges into the existing request.
    assign pend_d   = (pend_q & ~grant) | rise;

    assign evt_sel  = (address_dmem == EVT_ADDR);
    assign stat_sel = (address_dmem == STAT_ADDR);
    assign hit      = evt_sel | stat_sel;
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign pending  = ~empty;
    assign pop      = mem_read & evt_sel & ~empty;
    assign clr      = wren & stat_sel;
    assign do_push  = push_req & ~clr & (~full | pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (pop)     rptr_d = rptr_q + 1'b1;
            if (do_push && !pop)      count_d = count_q + 1'b1;
            else if (!do_push && pop) count_d = count_q - 1'b1;
            if (push_req && full && !pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            pend_q        <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            for (int i = 0; i < 4; i++)     cnt_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            pend_q        <= pend_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            if (do_push) mem_q[wptr_q] <= push_code;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (evt_sel) begin
            if (!empty) rdata = {29'b0, mem_q[rptr_q]};
        end else if (stat_sel) begin
            rdata     = 32'(count_q);
            rdata[31] = ovf_q;
        end
    end

endmodule
